mult_hilo_ctrl: RTL and testbench

Sequencer and HI/LO register file wrapped around the Booth multiplier (`multiplicador`). On a one-cycle `start` from the main control unit it latches the operands, holds the multiplier's `multOp` high for exactly `MULT_CYCLES` clocks, and captures `mult_hi`/`mult_lo` into the architectural HI/LO registers. It then pulses `done`. It also services mthi/mtlo writes, and HI/LO feed the datapath for mfhi/mflo.

---
 rtl/mult_hilo_ctrl_if.sv | 28 ++
 rtl/mult_hilo_ctrl.sv | 117 +++++++++++
 tb/tb_mult_hilo_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mult_hilo_ctrl_if.sv
// Bundles the control-unit, multiplier and datapath signals of the HI/LO multiply sequencer.
interface mult_hilo_ctrl_if;
    logic        start;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_write;
    logic        lo_write;
    logic [31:0] wdata;
    logic [31:0] mult_hi_in;
    logic [31:0] mult_lo_in;
    logic        multOp;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport slave (
        input  start, rs_data, rt_data, hi_write, lo_write, wdata, mult_hi_in, mult_lo_in,
        output multOp, multiplicand, multiplier, busy, done, hi, lo
    );

    modport master (
        output start, rs_data, rt_data, hi_write, lo_write, wdata, mult_hi_in, mult_lo_in,
        input  multOp, multiplicand, multiplier, busy, done, hi, lo
    );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// Sequencer around the Booth multiplier: latches operands, runs multOp for MULT_CYCLES
// edges, captures the product into HI/LO and services mthi/mtlo writes while idle.
module mult_hilo_ctrl #(
    parameter int MULT_CYCLES = 33
) (
    input logic             clk,
    input logic             reset,
    mult_hilo_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_CNT = 6'(MULT_CYCLES - 1);

    state_t      state_q,        state_d;
    logic [5:0]  cnt_q,          cnt_d;
    logic        mult_op_q,      mult_op_d;
    logic [31:0] multiplicand_q, multiplicand_d;
    logic [31:0] multiplier_q,   multiplier_d;
    logic [31:0] hi_q,           hi_d;
    logic [31:0] lo_q,           lo_d;
    logic        done_q,         done_d;

    // Next-state, operand latch and HI/LO update logic.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mult_op_d      = mult_op_q;
        multiplicand_d = multiplicand_q;
        multiplier_d   = multiplier_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        done_d         = 1'b0;

        case (state_q)
            IDLE: begin
                mult_op_d = 1'b0;
                if (bus.start) begin
                    // A start wins over any mthi/mtlo strobe in the same cycle.
                    multiplicand_d = bus.rs_data;
                    multiplier_d   = bus.rt_data;
                    cnt_d          = 6'd0;
                    mult_op_d      = 1'b1;
                    state_d        = RUN;
                end else begin
                    if (bus.hi_write) begin
                        hi_d = bus.wdata;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (bus.lo_write) begin
                        lo_d = bus.wdata;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            RUN: begin
                mult_op_d = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    mult_op_d = 1'b0;
                    state_d   = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            CAPTURE: begin
                // Product is still valid here; the multiplier clears on this same edge.
                mult_op_d = 1'b0;
                hi_d      = bus.mult_hi_in;
                lo_d      = bus.mult_lo_in;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                mult_op_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= 6'd0;
            mult_op_q      <= 1'b0;
            multiplicand_q <= 32'd0;
            multiplier_q   <= 32'd0;
            hi_q           <= 32'd0;
            lo_q           <= 32'd0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mult_op_q      <= mult_op_d;
            multiplicand_q <= multiplicand_d;
            multiplier_q   <= multiplier_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            done_q         <= done_d;
        end
    end

    assign bus.multOp       = mult_op_q;
    assign bus.multiplicand = multiplicand_q;
    assign bus.multiplier   = multiplier_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done_q;
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Scoreboard bench for mult_hilo_ctrl with a behavioural Booth-multiplier timing model.
module tb_mult_hilo_ctrl;

    localparam int M = 33;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   m_cnt = 0;
    bit   abort = 1'b0;
    exp_t sb_q[$];

    mult_hilo_ctrl_if bus ();

    mult_hilo_ctrl #(.MULT_CYCLES(M)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Multiplier model: product appears after M sampling edges with multOp high; clears when low.
    always @(posedge clk) begin
        longint pa, pb, prod;
        pa = longint'($signed(bus.multiplicand));
        pb = longint'($signed(bus.multiplier));
        prod = pa * pb;
        if (bus.multOp === 1'b1) begin
            if (m_cnt == M - 1) begin
                bus.mult_hi_in <= prod[63:32];
                bus.mult_lo_in <= prod[31:0];
            end
            m_cnt <= m_cnt + 1;
        end else begin
            if (m_cnt != 0 && !abort) chk("multop_edges", 64'(m_cnt), 64'(M));
            m_cnt <= 0;
            bus.mult_hi_in <= 32'd0;
            bus.mult_lo_in <= 32'd0;
        end
    end

    // Monitor: every done pulse must match the oldest expected product and its cycle.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_hi", 64'(bus.hi), 64'(e.hi));
                chk("sb_lo", 64'(bus.lo), 64'(e.lo));
                chk("sb_done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge after the start edge.
    task automatic do_start(input logic [31:0] rs, input logic [31:0] rt, input bit push,
                            input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        bus.start   = 1'b1;
        bus.rs_data = rs;
        bus.rt_data = rt;
        @(posedge clk);
        #1;
        if (push) begin
            e.hi  = eh;
            e.lo  = el;
            e.cyc = cyc + M + 1;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(bus.busy), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit bad;
        bus.start    = 1'b0;
        bus.rs_data  = 32'd0;
        bus.rt_data  = 32'd0;
        bus.hi_write = 1'b0;
        bus.lo_write = 1'b0;
        bus.wdata    = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_multop", 64'(bus.multOp), 64'd0);
        chk("rst_busy",   64'(bus.busy),   64'd0);
        chk("rst_done",   64'(bus.done),   64'd0);
        chk("rst_hi",     64'(bus.hi),     64'd0);
        chk("rst_lo",     64'(bus.lo),     64'd0);
        chk("rst_mcand",  64'(bus.multiplicand), 64'd0);
        chk("rst_mplier", 64'(bus.multiplier),   64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: 6*7, busy duration.
        do_start(32'd6, 32'd7, 1'b1, 32'h0000_0000, 32'h0000_002A);
        chk("t1_multop_on", 64'(bus.multOp), 64'd1);
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("t1_busy_cycles", 64'(n), 64'(M + 1));
        repeat (2) @(negedge clk);

        // 2: -3*5 with operand inputs changing during RUN.
        do_start(32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        bad = 1'b0;
        for (int i = 0; i < M; i++) begin
            bus.rs_data = $urandom;
            bus.rt_data = $urandom;
            if (bus.multiplicand !== 32'hFFFF_FFFD || bus.multiplier !== 32'd5) bad = 1'b1;
            @(negedge clk);
        end
        chk("t2_operands_frozen", 64'(bad), 64'd0);
        wait_idle();

        // 3: write rules.
        bus.hi_write = 1'b1;
        bus.wdata    = 32'h1234_5678;
        @(negedge clk);
        bus.hi_write = 1'b0;
        chk("t3_mthi_hi", 64'(bus.hi), 64'h1234_5678);
        chk("t3_mthi_lo", 64'(bus.lo), 64'hFFFF_FFF1);
        do_start(32'd2, 32'd3, 1'b1, 32'h0000_0000, 32'h0000_0006);
        repeat (5) @(negedge clk);
        bus.lo_write = 1'b1;
        bus.wdata    = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.lo_write = 1'b0;
        @(negedge clk);
        chk("t3_busy_write_lo", 64'(bus.lo), 64'hFFFF_FFF1);
        chk("t3_busy_write_hi", 64'(bus.hi), 64'h1234_5678);
        wait_idle();
        bus.lo_write = 1'b1;
        bus.wdata    = 32'hAAAA_5555;
        do_start(32'd4, 32'd5, 1'b1, 32'h0000_0000, 32'h0000_0014);
        bus.lo_write = 1'b0;
        chk("t3_start_drops_write", 64'(bus.lo), 64'h0000_0006);
        chk("t3_start_taken", 64'(bus.busy), 64'd1);
        wait_idle();

        // 4: back-to-back start in the done cycle.
        do_start(32'd1, 32'd1, 1'b1, 32'h0000_0000, 32'h0000_0001);
        n = 0;
        while (!bus.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t4_done_seen", 64'(bus.done), 64'd1);
        chk("t4_multop_low_in_done", 64'(bus.multOp), 64'd0);
        do_start(32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0001, 32'h0000_0000);
        chk("t4_b2b_multop", 64'(bus.multOp), 64'd1);
        chk("t4_b2b_mcand", 64'(bus.multiplicand), 64'h0001_0000);
        wait_idle();

        // 5: reset during RUN aborts with no done.
        do_start(32'd9, 32'd9, 1'b0, 32'd0, 32'd0);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("t5_multop", 64'(bus.multOp), 64'd0);
        chk("t5_busy",   64'(bus.busy),   64'd0);
        chk("t5_hi",     64'(bus.hi),     64'd0);
        chk("t5_lo",     64'(bus.lo),     64'd0);
        chk("t5_done",   64'(bus.done),   64'd0);
        chk("t5_mcand",  64'(bus.multiplicand), 64'd0);
        reset = 1'b0;
        repeat (M + 5) @(negedge clk);
        abort = 1'b0;
        do_start(32'd100, 32'd200, 1'b1, 32'h0000_0000, 32'h0000_4E20);
        wait_idle();

        // 6: held start gives one operation; start while busy is ignored.
        do_start(32'd3, 32'd3, 1'b1, 32'h0000_0000, 32'h0000_0009);
        n = 1;
        for (int i = 0; i < 200 && bus.busy; i++) begin
            n++;
            bus.start   = (i < 2) || (i == 10);
            bus.rs_data = 32'd50;
            bus.rt_data = 32'd50;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("t6_busy_cycles", 64'(n - 1), 64'(M + 1));
        chk("t6_mcand", 64'(bus.multiplicand), 64'd3);
        repeat (M + 10) @(negedge clk);
        chk("t6_still_idle", 64'(bus.busy), 64'd0);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
